lc3b_line_cache: RTL and testbench
==================================

Name: lc3b_line_cache

Overview:
- Parametrised direct-mapped, write-back, write-allocate cache between the LC-3b CPU memory port and a line-wide physical memory.
- The CPU-side port matches the existing CPU memory handshake: mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata, mem_rdata and mem_resp.
- The physical side moves whole lines per transaction.
- Intended as the drop-in memory stage of the next-generation processor top level.

Parameters:
- ADDR_W, 16, byte-address width.
- WORD_W, 16, CPU word width in bits; must be 16 (two byte lanes).
- NUM_LINES, 8, number of lines; power of two, at least 2.
- LINE_WORDS, 8, words per line; power of two, at least 2.
- Derived values:
  - LINE_W = WORD_W*LINE_WORDS.
  - OFF_B = log2(LINE_WORDS*2).
  - IDX_B = log2(NUM_LINES).
  - TAG_B = ADDR_W-OFF_B-IDX_B.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_read  in  1  CPU read request; held until mem_resp.
- mem_write  in  1  CPU write request; held until mem_resp.
- mem_byte_enable  in  2  write lane mask: bit0 = byte [7:0], bit1 = byte [15:8].
- mem_address  in  ADDR_W  CPU byte address; bit 0 is ignored for word selection.
- mem_wdata  in  WORD_W  CPU write data.
- mem_rdata  out  WORD_W  CPU read data; valid while mem_resp=1.
- mem_resp  out  1  one-cycle completion pulse.
- pmem_read  out  1  line-fill request; held until pmem_resp.
- pmem_write  out  1  line-writeback request; held until pmem_resp.
- pmem_address  out  ADDR_W  line-aligned address; low OFF_B bits are 0.
- pmem_wdata  out  LINE_W  victim line data.
- pmem_rdata  in  LINE_W  fill data; sampled in the pmem_resp cycle.
- pmem_resp  in  1  physical-memory completion.

Behaviour:
- Address split: tag = addr[ADDR_W-1:OFF_B], index = addr[OFF_B+IDX_B-1:OFF_B], word = addr[OFF_B-1:1].
- Storage per line: valid bit, dirty bit, TAG_B tag, LINE_W data. Data arrays are not reset; valid and dirty are cleared on reset.
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE.
  - All valid and dirty bits are cleared.
  - mem_resp, pmem_read and pmem_write go to 0 immediately.
  - mem_rdata, pmem_address and pmem_wdata go to 0.
  - Reset mid-miss abandons the transaction with no partial line update.
- States: IDLE, RESP, WRITEBACK, ALLOCATE.
- IDLE:
  - Request = mem_read | mem_write. If both are asserted, the request is treated as a write.
  - Hit = valid[index] & (tag == stored tag).
  - Request and hit, read: the addressed word is latched into mem_rdata; go to RESP.
  - Request and hit, write: the enabled bytes of the addressed word are merged into the line and dirty is set at the same edge; go to RESP. Non-enabled bytes are unchanged. A mask of 2'b00 still completes and still sets dirty.
  - Request, miss, victim dirty: go to WRITEBACK.
  - Request, miss, victim clean or invalid: go to ALLOCATE.
- RESP:
  - mem_resp=1 for exactly one cycle, then go to IDLE.
  - A request still asserted in the cycle after RESP is treated as a new request.
- WRITEBACK:
  - pmem_write=1, pmem_address = {stored tag, index, 0}, pmem_wdata = stored line.
  - All three are held stable until pmem_resp. On pmem_resp, clear dirty and go to ALLOCATE.
- ALLOCATE:
  - pmem_read=1, pmem_address = {request tag, index, 0}.
  - On pmem_resp: data is loaded from pmem_rdata, the tag is written, valid=1, dirty=0; go to IDLE.
  - The request is re-evaluated in IDLE and hits.
- pmem_read and pmem_write are never asserted together.
- Latency:
  - Hit: mem_resp in the 2nd cycle after the request is first seen (1 wait state).
  - Clean miss: 1 + fill cycles + 2.
  - Dirty miss: additionally adds the writeback cycles.
- pmem_resp outside WRITEBACK or ALLOCATE is ignored.
- CPU inputs are sampled only in IDLE; they must remain stable until mem_resp.

Optional Feature:
- Macro: LC3B_CACHE_STATS_EN.
- Defined: adds ports hit_count (out, 16) and miss_count (out, 16).
  - hit_count increments on each IDLE hit transition, excluding the re-hit that follows an allocate.
  - miss_count increments on each IDLE miss transition.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset, then read 0x0040 -> ALLOCATE drives pmem_read with pmem_address=0x0040. Return a line with word0=0x1234 -> mem_resp pulse with mem_rdata=0x1234; no pmem_write occurs.
- Repeat read 0x0040 -> mem_resp 2 cycles after the request; pmem_read stays 0.
- Write 0x0042, byte_enable=2'b10, wdata=0xAB00 -> the next read of 0x0042 returns 0xABxx, where xx is the original low byte of the filled word.
- Dirty line at index 4, then read conflicting address 0x00C0:
  - pmem_write first, with pmem_address=0x0040 and the modified line on pmem_wdata, held across a 5-cycle pmem_resp delay.
  - Then pmem_read with pmem_address=0x00C0.
- Assert rst_n=0 while pmem_read=1 -> pmem_read drops without a clock edge. The next read of 0x0040 misses, since valid was cleared.
- With LC3B_CACHE_STATS_EN: the sequence miss, hit, hit, miss -> hit_count=2, miss_count=2.

Source files
------------

// File: rtl/lc3b_line_cache.sv
// ============================================================================
// lc3b_line_cache
// ----------------------------------------------------------------------------
// Direct-mapped, write-back, write-allocate cache that sits between the
// LC-3b CPU memory port (word-wide, byte-enabled) and a physical memory that
// transfers whole lines per transaction.
//
// Optional build macro: LC3B_CACHE_STATS_EN
//   When defined, the saturating 16-bit hit_count / miss_count outputs are
//   added. When undefined, the ports and counters do not exist.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   mem_read/mem_write  CPU request strobes, held until mem_resp
//   mem_byte_enable     write lane mask (bit0 -> [7:0], bit1 -> [15:8])
//   mem_address         CPU byte address (bit 0 ignored for word selection)
//   mem_wdata           CPU write data
//   mem_rdata           CPU read data, valid while mem_resp is high
//   mem_resp            one-cycle completion pulse
//   pmem_read           line fill request, held until pmem_resp
//   pmem_write          line writeback request, held until pmem_resp
//   pmem_address        line-aligned physical address
//   pmem_wdata          victim line data
//   pmem_rdata          fill line data, sampled in the pmem_resp cycle
//   pmem_resp           physical memory completion
//   hit_count/miss_count (LC3B_CACHE_STATS_EN only) saturating statistics
// ============================================================================
module lc3b_line_cache #(
    parameter int ADDR_W     = 16,
    parameter int WORD_W     = 16,
    parameter int NUM_LINES  = 8,
    parameter int LINE_WORDS = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         mem_read,
    input  logic                         mem_write,
    input  logic [1:0]                   mem_byte_enable,
    input  logic [ADDR_W-1:0]            mem_address,
    input  logic [WORD_W-1:0]            mem_wdata,
    output logic [WORD_W-1:0]            mem_rdata,
    output logic                         mem_resp,
    output logic                         pmem_read,
    output logic                         pmem_write,
    output logic [ADDR_W-1:0]            pmem_address,
    output logic [WORD_W*LINE_WORDS-1:0] pmem_wdata,
    input  logic [WORD_W*LINE_WORDS-1:0] pmem_rdata,
    input  logic                         pmem_resp
`ifdef LC3B_CACHE_STATS_EN
    ,
    output logic [15:0]                  hit_count,
    output logic [15:0]                  miss_count
`endif
);

    localparam int LINE_W = WORD_W * LINE_WORDS;
    localparam int OFF_B  = $clog2(LINE_WORDS * 2);
    localparam int IDX_B  = $clog2(NUM_LINES);
    localparam int TAG_B  = ADDR_W - OFF_B - IDX_B;
    localparam int SEL_B  = OFF_B - 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RESP      = 2'd1,
        ST_WRITEBACK = 2'd2,
        ST_ALLOCATE  = 2'd3
    } state_e;

    // ------------------------------------------------------------------
    // State and storage
    // ------------------------------------------------------------------
    state_e                 state_q;
    logic [NUM_LINES-1:0]   valid_q;
    logic [NUM_LINES-1:0]   dirty_q;
    logic [LINE_W-1:0]      data_q [NUM_LINES];
    logic [TAG_B-1:0]       tag_q  [NUM_LINES];

    // The miss being serviced is latched so that WRITEBACK/ALLOCATE do not
    // depend on the CPU inputs after IDLE.
    logic [TAG_B-1:0]       fill_tag_q;
    logic [IDX_B-1:0]       fill_idx_q;

    logic                   mem_resp_q;
    logic [WORD_W-1:0]      mem_rdata_q;
    logic                   pmem_read_q;
    logic                   pmem_write_q;
    logic [ADDR_W-1:0]      pmem_address_q;
    logic [LINE_W-1:0]      pmem_wdata_q;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [TAG_B-1:0]       req_tag_s;
    logic [IDX_B-1:0]       req_idx_s;
    logic [OFF_B-1:0]       req_off_s;
    logic [SEL_B-1:0]       word_s;
    logic                   request_s;
    logic                   is_write_s;
    logic [LINE_W-1:0]      line_s;
    logic [TAG_B-1:0]       stag_s;
    logic                   hit_s;
    logic                   victim_dirty_s;
    logic [WORD_W-1:0]      rd_word_s;
    logic [LINE_W-1:0]      merged_line_s;
    logic                   hit_wr_s;
    logic                   fill_we_s;

    assign req_tag_s  = mem_address[ADDR_W-1 -: TAG_B];
    assign req_idx_s  = mem_address[OFF_B +: IDX_B];
    assign req_off_s  = mem_address[OFF_B-1:0];
    // Byte bit 0 is dropped: the word select is the offset in words.
    assign word_s     = SEL_B'(req_off_s >> 1);
    assign request_s  = mem_read | mem_write;
    // Read and write together is serviced as a write.
    assign is_write_s = mem_write;

    assign line_s         = data_q[req_idx_s];
    assign stag_s         = tag_q[req_idx_s];
    assign hit_s          = valid_q[req_idx_s] && (stag_s == req_tag_s);
    assign victim_dirty_s = valid_q[req_idx_s] && dirty_q[req_idx_s];

    assign hit_wr_s  = (state_q == ST_IDLE) && request_s && hit_s && is_write_s;
    assign fill_we_s = (state_q == ST_ALLOCATE) && pmem_resp;

    // Word extraction for reads and byte-lane merge for write hits
    always_comb begin
        rd_word_s     = {WORD_W{1'b0}};
        merged_line_s = line_s;
        for (int w = 0; w < LINE_WORDS; w++) begin
            if (SEL_B'(w) == word_s) begin
                rd_word_s = line_s[w*WORD_W +: WORD_W];
                if (mem_byte_enable[0]) begin
                    merged_line_s[w*WORD_W +: 8] = mem_wdata[7:0];
                end else begin
                    merged_line_s[w*WORD_W +: 8] = line_s[w*WORD_W +: 8];
                end
                if (mem_byte_enable[1]) begin
                    merged_line_s[w*WORD_W+8 +: 8] = mem_wdata[15:8];
                end else begin
                    merged_line_s[w*WORD_W+8 +: 8] = line_s[w*WORD_W+8 +: 8];
                end
            end else begin
                merged_line_s[w*WORD_W +: WORD_W] = line_s[w*WORD_W +: WORD_W];
            end
        end
    end

    // Line data and tag storage: not reset, written by fills and write hits
    always_ff @(posedge clk) begin
        if (fill_we_s) begin
            data_q[fill_idx_q] <= pmem_rdata;
            tag_q[fill_idx_q]  <= fill_tag_q;
        end else if (hit_wr_s) begin
            data_q[req_idx_s]  <= merged_line_s;
        end
    end

    // Controller FSM with registered CPU and physical-memory outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            valid_q        <= {NUM_LINES{1'b0}};
            dirty_q        <= {NUM_LINES{1'b0}};
            fill_tag_q     <= {TAG_B{1'b0}};
            fill_idx_q     <= {IDX_B{1'b0}};
            mem_resp_q     <= 1'b0;
            mem_rdata_q    <= {WORD_W{1'b0}};
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= {ADDR_W{1'b0}};
            pmem_wdata_q   <= {LINE_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    mem_resp_q <= 1'b0;
                    if (request_s) begin
                        if (hit_s) begin
                            if (is_write_s) begin
                                // Dirty is set even for an all-zero lane mask.
                                dirty_q[req_idx_s] <= 1'b1;
                            end else begin
                                mem_rdata_q <= rd_word_s;
                            end
                            mem_resp_q <= 1'b1;
                            state_q    <= ST_RESP;
                        end else begin
                            fill_tag_q <= req_tag_s;
                            fill_idx_q <= req_idx_s;
                            if (victim_dirty_s) begin
                                pmem_write_q   <= 1'b1;
                                pmem_address_q <= {stag_s, req_idx_s, {OFF_B{1'b0}}};
                                pmem_wdata_q   <= line_s;
                                state_q        <= ST_WRITEBACK;
                            end else begin
                                pmem_read_q    <= 1'b1;
                                pmem_address_q <= {req_tag_s, req_idx_s, {OFF_B{1'b0}}};
                                state_q        <= ST_ALLOCATE;
                            end
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RESP: begin
                    mem_resp_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                ST_WRITEBACK: begin
                    if (pmem_resp) begin
                        // Hand over straight to the fill; read and write
                        // never overlap because they swap on the same edge.
                        dirty_q[fill_idx_q] <= 1'b0;
                        pmem_write_q        <= 1'b0;
                        pmem_read_q         <= 1'b1;
                        pmem_address_q      <= {fill_tag_q, fill_idx_q, {OFF_B{1'b0}}};
                        state_q             <= ST_ALLOCATE;
                    end else begin
                        state_q <= ST_WRITEBACK;
                    end
                end
                ST_ALLOCATE: begin
                    if (pmem_resp) begin
                        valid_q[fill_idx_q] <= 1'b1;
                        dirty_q[fill_idx_q] <= 1'b0;
                        pmem_read_q         <= 1'b0;
                        state_q             <= ST_IDLE;
                    end else begin
                        state_q <= ST_ALLOCATE;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    mem_resp_q   <= 1'b0;
                    pmem_read_q  <= 1'b0;
                    pmem_write_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef LC3B_CACHE_STATS_EN
    logic [15:0] hit_count_q;
    logic [15:0] miss_count_q;
    // Set when a fill completes so the guaranteed re-hit is not counted.
    logic        refill_q;

    // Saturating hit/miss statistics sampled on IDLE decisions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count_q  <= 16'd0;
            miss_count_q <= 16'd0;
            refill_q     <= 1'b0;
        end else begin
            if (fill_we_s) begin
                refill_q <= 1'b1;
            end else if ((state_q == ST_IDLE) && request_s) begin
                refill_q <= 1'b0;
                if (hit_s) begin
                    if (!refill_q && (hit_count_q != 16'hFFFF)) begin
                        hit_count_q <= hit_count_q + 16'd1;
                    end else begin
                        hit_count_q <= hit_count_q;
                    end
                end else begin
                    if (miss_count_q != 16'hFFFF) begin
                        miss_count_q <= miss_count_q + 16'd1;
                    end else begin
                        miss_count_q <= miss_count_q;
                    end
                end
            end else begin
                refill_q <= refill_q;
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

    assign mem_resp     = mem_resp_q;
    assign mem_rdata    = mem_rdata_q;
    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = pmem_address_q;
    assign pmem_wdata   = pmem_wdata_q;

endmodule

// File: tb/tb_lc3b_line_cache.sv
// ============================================================================
// tb_lc3b_line_cache
// ----------------------------------------------------------------------------
// Self-checking bench for lc3b_line_cache. The CPU view is modelled as a flat
// word memory (a write-back cache is transparent), the physical side as a
// second flat memory served by a responder with random latency. A small
// per-index tag/dirty table predicts which physical transactions a request
// must cause and how long it must take.
// ============================================================================
module tb_lc3b_line_cache;

    localparam int MW = 1024;

    logic         clk;
    logic         rst_n;
    logic         mem_read;
    logic         mem_write;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_address;
    logic [15:0]  mem_wdata;
    logic [15:0]  mem_rdata;
    logic         mem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
`ifdef LC3B_CACHE_STATS_EN
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;
`endif

    lc3b_line_cache dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
`ifdef LC3B_CACHE_STATS_EN
        ,
        .hit_count       (hit_count),
        .miss_count      (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        int          dly;
    } evt_t;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    logic [15:0] shadow   [MW];
    logic [15:0] pmem_arr [MW];
    bit          tm_valid [8];
    bit          tm_dirty [8];
    int          tm_tag   [8];
    evt_t        evq[$];
    bit          rsp_en = 1'b1;
    int          force_wb_dly = -1;
    int          hits_m = 0;
    int          misses_m = 0;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [127:0] shadow_line(input int base);
        logic [127:0] l;
        for (int k = 0; k < 8; k++) l[k*16 +: 16] = shadow[(base + k) % MW];
        return l;
    endfunction

    // Physical memory responder
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            if (rsp_en && rst_n && (pmem_read || pmem_write)) begin
                bit           w;
                logic [15:0]  a;
                logic [127:0] wd;
                int           d;
                int           base;
                check_eq("pmem_excl", {126'd0, pmem_read, pmem_write} & 128'd3, pmem_write ? 128'd1 : 128'd2);
                w    = pmem_write;
                a    = pmem_address;
                wd   = pmem_wdata;
                base = int'(a >> 1);
                check_eq("pmem_align", {124'd0, a[3:0]}, 128'd0);
                if (w && force_wb_dly >= 0) begin
                    d = force_wb_dly;
                    force_wb_dly = -1;
                end else begin
                    d = $urandom_range(0, 3);
                end
                if (w) check_eq("wb_data", wd, shadow_line(base));
                repeat (d) begin
                    @(negedge clk);
                    check_eq("pmem_hold_addr", {112'd0, pmem_address}, {112'd0, a});
                    check_eq("pmem_hold_req", {126'd0, pmem_write, pmem_read}, w ? 128'd2 : 128'd1);
                    if (w) check_eq("pmem_hold_data", pmem_wdata, wd);
                end
                if (w) begin
                    for (int k = 0; k < 8; k++) pmem_arr[(base + k) % MW] = wd[k*16 +: 16];
                end else begin
                    for (int k = 0; k < 8; k++) pmem_rdata[k*16 +: 16] = pmem_arr[(base + k) % MW];
                end
                evq.push_back('{w, a, d});
                pmem_resp = 1'b1;
                @(negedge clk);
                pmem_resp = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    end

    // One CPU access, called and returning at a negedge
    task automatic cpu_access(input bit rd, input bit wr, input logic [15:0] addr,
                              input logic [1:0] be, input logic [15:0] wd);
        int   idx, tg, wi, vtag, edges, exp_n, exp_lat;
        bit   hit, vdirty, got;
        idx    = int'(addr[6:4]);
        tg     = int'(addr[15:7]);
        wi     = int'(addr >> 1) % MW;
        hit    = tm_valid[idx] && (tm_tag[idx] == tg);
        vdirty = !hit && tm_valid[idx] && tm_dirty[idx];
        vtag   = tm_tag[idx];
        evq.delete();
        mem_read        = rd;
        mem_write       = wr;
        mem_address     = addr;
        mem_byte_enable = be;
        mem_wdata       = wd;
        edges = 0;
        got   = 1'b0;
        while (!got && edges < 300) begin
            @(negedge clk);
            edges++;
            if (mem_resp) got = 1'b1;
        end
        check_eq("resp_timeout", {127'd0, got}, 128'd1);
        if (!wr) check_eq("rdata", {112'd0, mem_rdata}, {112'd0, shadow[wi]});
        mem_read  = 1'b0;
        mem_write = 1'b0;
        exp_n = hit ? 0 : (vdirty ? 2 : 1);
        check_eq("pmem_txn_count", evq.size(), exp_n);
        if (evq.size() == exp_n) begin
            if (exp_n == 0) exp_lat = 1;
            else if (exp_n == 1) exp_lat = 3 + evq[0].dly;
            else exp_lat = 4 + evq[0].dly + evq[1].dly;
            check_eq("latency", edges, exp_lat);
            if (exp_n == 2) begin
                check_eq("wb_first", {127'd0, evq[0].wr}, 128'd1);
                check_eq("wb_addr", {112'd0, evq[0].addr}, {112'd0, 16'(vtag * 128 + idx * 16)});
            end
            if (exp_n > 0) begin
                check_eq("fill_is_read", {127'd0, evq[exp_n-1].wr}, 128'd0);
                check_eq("fill_addr", {112'd0, evq[exp_n-1].addr}, {112'd0, addr & 16'hFFF0});
            end
        end
        if (wr) begin
            if (be[0]) shadow[wi][7:0]  = wd[7:0];
            if (be[1]) shadow[wi][15:8] = wd[15:8];
        end
        if (hit) hits_m++; else misses_m++;
        tm_valid[idx] = 1'b1;
        tm_tag[idx]   = tg;
        tm_dirty[idx] = hit ? (tm_dirty[idx] | wr) : wr;
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            tm_valid[i] = 1'b0;
            tm_dirty[i] = 1'b0;
            tm_tag[i]   = 0;
        end
        for (int i = 0; i < MW; i++) shadow[i] = pmem_arr[i];
        hits_m   = 0;
        misses_m = 0;
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0;
        mem_read = 1'b0;
        mem_write = 1'b0;
        mem_byte_enable = 2'b00;
        mem_address = 16'h0000;
        mem_wdata = 16'h0000;
        for (int i = 0; i < MW; i++) pmem_arr[i] = 16'($urandom);
        pmem_arr[32] = 16'h1234;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_mem_resp", {127'd0, mem_resp}, 128'd0);
        check_eq("rst_pmem_read", {127'd0, pmem_read}, 128'd0);
        check_eq("rst_pmem_write", {127'd0, pmem_write}, 128'd0);
        check_eq("rst_pmem_address", {112'd0, pmem_address}, 128'd0);
        check_eq("rst_mem_rdata", {112'd0, mem_rdata}, 128'd0);
        check_eq("rst_pmem_wdata", pmem_wdata, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Cold read, repeat hit, partial write, then dirty conflict
        cpu_access(1'b1, 1'b0, 16'h0040, 2'b00, 16'h0000);
        cpu_access(1'b1, 1'b0, 16'h0040, 2'b00, 16'h0000);
        cpu_access(1'b0, 1'b1, 16'h0042, 2'b10, 16'hAB00);
        cpu_access(1'b1, 1'b0, 16'h0042, 2'b00, 16'h0000);
        check_eq("be_merge_hi", {120'd0, mem_rdata[15:8]}, {120'd0, 8'hAB});
        force_wb_dly = 5;
        cpu_access(1'b1, 1'b0, 16'h00C0, 2'b00, 16'h0000);

        // Reset during an outstanding fill
        rsp_en = 1'b0;
        mem_read = 1'b1;
        mem_address = 16'h0040;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (pmem_read) seen = 1'b1;
        end
        check_eq("fill_req_seen", {127'd0, seen}, 128'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_pmem_read", {127'd0, pmem_read}, 128'd0);
        check_eq("async_rst_pmem_address", {112'd0, pmem_address}, 128'd0);
        check_eq("async_rst_mem_resp", {127'd0, mem_resp}, 128'd0);
        mem_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rsp_en = 1'b1;
        model_reset();
        @(negedge clk);
        cpu_access(1'b1, 1'b0, 16'h0040, 2'b00, 16'h0000);

        // Randomised traffic over four tags to force conflicts
        for (int n = 0; n < 200; n++) begin
            int op;
            op = $urandom_range(0, 2);
            cpu_access(op != 1, op != 0, 16'($urandom_range(0, 511)),
                       2'($urandom_range(0, 3)), 16'($urandom));
        end

`ifdef LC3B_CACHE_STATS_EN
        check_eq("hit_count", {112'd0, hit_count}, 128'(hits_m));
        check_eq("miss_count", {112'd0, miss_count}, 128'(misses_m));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
